// File: rtl/tree_node_dispatch.sv
// rtl/tree_node_dispatch.sv - interior tree node: one upstream port dispatched to NUM_CHILDREN credited child ports
module tree_node_dispatch #(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 32,
    parameter int MODE         = 0,
    parameter int MAX_OUT      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    up_valid_i,
    output logic                    up_ready_o,
    input  logic [DATA_W-1:0]       up_data_i,
    output logic [NUM_CHILDREN-1:0] dn_valid_o,
    input  logic [NUM_CHILDREN-1:0] dn_ready_i,
    output logic [DATA_W-1:0]       dn_data_o,
    input  logic [NUM_CHILDREN-1:0] dn_done_i,
    output logic                    busy_o,
    output logic                    err_sel_o,
    output logic                    err_done_o
);
    localparam int SEL_W = $clog2(NUM_CHILDREN);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic {EMPTY, FULL} slot_state_e;

    slot_state_e              state_q;
    logic [NUM_CHILDREN-1:0]  dn_valid_q;
    logic [DATA_W-1:0]        dn_data_q;
    logic [SEL_W-1:0]         rr_ptr_q;
    logic [CNT_W-1:0]         cnt_q [NUM_CHILDREN];
    logic                     err_sel_q;
    logic                     err_done_q;

    logic [NUM_CHILDREN-1:0]  credit;
    logic [NUM_CHILDREN-1:0]  cnt_zero;
    logic [NUM_CHILDREN-1:0]  load_onehot;
    logic [SEL_W-1:0]         addr_idx;
    logic [SEL_W-1:0]         tgt;
    logic [SEL_W-1:0]         rr_ptr_d;
    logic                     rr_found;
    logic                     addr_ok;
    logic                     addr_credit;
    logic                     credit_ok;
    logic                     slot_vld;
    logic                     slot_fire;
    logic                     accept;
    logic                     drop;
    logic                     load;
    int                       j;

    assign addr_idx  = up_data_i[DATA_W-1 -: SEL_W];
    assign slot_vld  = (state_q == FULL);
    assign slot_fire = |(dn_valid_q & dn_ready_i);

    always_comb begin
        credit   = '0;
        cnt_zero = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            credit[i]   = (cnt_q[i] < CNT_W'(MAX_OUT));
            cnt_zero[i] = (cnt_q[i] == '0);
        end
    end

    // Round-robin search starts at rr_ptr and wraps; addressed mode just decodes the index.
    always_comb begin
        tgt         = '0;
        rr_found    = 1'b0;
        addr_ok     = 1'b0;
        addr_credit = 1'b0;
        j           = 0;
        if (MODE == 0) begin
            for (int k = 0; k < NUM_CHILDREN; k++) begin
                j = int'(rr_ptr_q) + k;
                if (j >= NUM_CHILDREN) j = j - NUM_CHILDREN;
                if (!rr_found && credit[j]) begin
                    rr_found = 1'b1;
                    tgt      = SEL_W'(j);
                end
            end
        end else begin
            tgt = addr_idx;
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                if (addr_idx == SEL_W'(i)) begin
                    addr_ok     = 1'b1;
                    addr_credit = credit[i];
                end
            end
        end
    end

    assign credit_ok   = (MODE == 0) ? rr_found : (addr_ok ? addr_credit : 1'b1);
    assign up_ready_o  = (!slot_vld || slot_fire) && credit_ok;
    assign accept      = up_valid_i && up_ready_o;
    assign drop        = (MODE != 0) && !addr_ok;
    assign load        = accept && !drop;
    assign load_onehot = load ? (NUM_CHILDREN'(1) << tgt) : '0;
    assign rr_ptr_d    = (tgt == SEL_W'(NUM_CHILDREN - 1)) ? '0 : tgt + SEL_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            dn_valid_q <= '0;
            dn_data_q  <= '0;
            rr_ptr_q   <= '0;
            err_sel_q  <= 1'b0;
            err_done_q <= 1'b0;
            for (int i = 0; i < NUM_CHILDREN; i++) cnt_q[i] <= '0;
        end else begin
            err_sel_q  <= accept && drop;
            err_done_q <= |(dn_done_i & cnt_zero);
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_q    <= FULL;
                        dn_valid_q <= load_onehot;
                        dn_data_q  <= up_data_i;
                    end
                end
                FULL: begin
                    if (load) begin
                        dn_valid_q <= load_onehot;
                        dn_data_q  <= up_data_i;
                    end else if (slot_fire) begin
                        state_q    <= EMPTY;
                        dn_valid_q <= '0;
                    end
                end
                default: state_q <= EMPTY;
            endcase
            if (MODE == 0 && accept) rr_ptr_q <= rr_ptr_d;
            // Reservation and release in one cycle cancel; a release at zero is reported, not applied.
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                case ({load_onehot[i], dn_done_i[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    2'b01:   if (!cnt_zero[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    assign dn_valid_o = dn_valid_q;
    assign dn_data_o  = dn_data_q;
    assign busy_o     = slot_vld || !(&cnt_zero);
    assign err_sel_o  = err_sel_q;
    assign err_done_o = err_done_q;
endmodule

// File: tb/tb_tree_node_dispatch.sv
// tb/tb_tree_node_dispatch.sv - directed table-driven bench for tree_node_dispatch
module tb_tree_node_dispatch;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_up_valid, a_up_ready, a_busy, a_err_sel, a_err_done;
    logic [31:0] a_up_data, a_dn_data;
    logic [4:0]  a_dn_valid, a_dn_ready, a_dn_done;
    logic        b_up_valid, b_up_ready, b_busy, b_err_sel, b_err_done;
    logic [31:0] b_up_data, b_dn_data;
    logic [4:0]  b_dn_valid, b_dn_ready, b_dn_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  exp_valid;
        logic        exp_err_sel;
    } vec_t;

    vec_t t1 [10];
    vec_t t3 [3];

    always #5 clk = ~clk;

    tree_node_dispatch #(.NUM_CHILDREN(5), .DATA_W(32), .MODE(0), .MAX_OUT(2)) u_rr (
        .clk_i(clk), .rst_i(rst), .up_valid_i(a_up_valid), .up_ready_o(a_up_ready),
        .up_data_i(a_up_data), .dn_valid_o(a_dn_valid), .dn_ready_i(a_dn_ready),
        .dn_data_o(a_dn_data), .dn_done_i(a_dn_done), .busy_o(a_busy),
        .err_sel_o(a_err_sel), .err_done_o(a_err_done)
    );

    tree_node_dispatch #(.NUM_CHILDREN(5), .DATA_W(32), .MODE(1), .MAX_OUT(4)) u_addr (
        .clk_i(clk), .rst_i(rst), .up_valid_i(b_up_valid), .up_ready_o(b_up_ready),
        .up_data_i(b_up_data), .dn_valid_o(b_dn_valid), .dn_ready_i(b_dn_ready),
        .dn_data_o(b_dn_data), .dn_done_i(b_dn_done), .busy_o(b_busy),
        .err_sel_o(b_err_sel), .err_done_o(b_err_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_up_valid = 1'b0; a_up_data = '0; a_dn_ready = 5'h1f; a_dn_done = '0;
        b_up_valid = 1'b0; b_up_data = '0; b_dn_ready = 5'h1f; b_dn_done = '0;
        for (int k = 0; k < 10; k++) begin
            t1[k].data        = 32'(k);
            t1[k].exp_valid   = 5'(1 << (k % 5));
            t1[k].exp_err_sel = 1'b0;
        end
        t3[0] = '{32'h4000_0011, 5'b00100, 1'b0};
        t3[1] = '{32'hE000_0022, 5'b00000, 1'b1};
        t3[2] = '{32'h4000_0033, 5'b00100, 1'b0};

        tick(); tick();
        chk("rst_dn_valid", 32'(a_dn_valid), 0);
        chk("rst_dn_data", a_dn_data, 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_err_sel", 32'(a_err_sel), 0);
        chk("rst_err_done", 32'(a_err_done), 0);
        rst = 1'b0;
        #1;
        chk("rst_up_ready_a", 32'(a_up_ready), 1);
        chk("rst_up_ready_b", 32'(b_up_ready), 1);

        // Round-robin order, one beat per clock, latency 1
        for (int k = 0; k < 10; k++) begin
            a_up_valid = 1'b1;
            a_up_data  = t1[k].data;
            #1;
            chk("rr_up_ready", 32'(a_up_ready), 1);
            if (k == 0) chk("rr_latency_pre", 32'(a_dn_valid), 0);
            tick();
            chk("rr_dn_valid", 32'(a_dn_valid), 32'(t1[k].exp_valid));
            chk("rr_dn_data", a_dn_data, t1[k].data);
        end

        // Credit exhaustion at MAX_OUT=2, then a single release on child 3
        a_up_data = 32'd50;
        #1;
        chk("cr_exhausted", 32'(a_up_ready), 0);
        chk("cr_busy", 32'(a_busy), 1);
        tick();
        chk("cr_slot_drained", 32'(a_dn_valid), 0);
        a_dn_done = 5'b01000;
        #1;
        chk("cr_still_blocked", 32'(a_up_ready), 0);
        tick();
        a_dn_done = '0;
        #1;
        chk("cr_released", 32'(a_up_ready), 1);
        tick();
        chk("cr_to_child3", 32'(a_dn_valid), 32'h8);
        chk("cr_data", a_dn_data, 32'd50);
        chk("cr_blocked_again", 32'(a_up_ready), 0);
        a_up_valid = 1'b0;

        // Backpressure on child 1 holds the slot stable
        rst = 1'b1; tick(); rst = 1'b0;
        a_dn_ready = 5'b11101;
        a_up_valid = 1'b1; a_up_data = 32'hA0;
        tick();
        a_up_data = 32'hB1;
        tick();
        chk("bp_child1", 32'(a_dn_valid), 32'h2);
        a_up_data = 32'hC2;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("bp_up_ready", 32'(a_up_ready), 0);
            chk("bp_dn_valid", 32'(a_dn_valid), 32'h2);
            chk("bp_dn_data", a_dn_data, 32'hB1);
            tick();
        end
        a_dn_ready = 5'h1f;
        #1;
        chk("bp_release_ready", 32'(a_up_ready), 1);
        tick();
        chk("bp_next_child2", 32'(a_dn_valid), 32'h4);
        chk("bp_next_data", a_dn_data, 32'hC2);
        a_up_valid = 1'b0;
        tick();

        // Reset with slot full and counts nonzero
        a_dn_ready = '0;
        a_up_valid = 1'b1; a_up_data = 32'hD3;
        tick();
        a_up_valid = 1'b0;
        chk("mr_slot_child3", 32'(a_dn_valid), 32'h8);
        chk("mr_busy_pre", 32'(a_busy), 1);
        rst = 1'b1;
        tick();
        chk("mr_dn_valid", 32'(a_dn_valid), 0);
        chk("mr_dn_data", a_dn_data, 0);
        chk("mr_busy", 32'(a_busy), 0);
        rst = 1'b0;
        a_dn_ready = 5'h1f;
        #1;
        chk("mr_up_ready", 32'(a_up_ready), 1);
        a_up_valid = 1'b1; a_up_data = 32'hE0;
        tick();
        chk("mr_rr_ptr_zero", 32'(a_dn_valid), 32'h1);
        a_up_valid = 1'b0;

        // Addressed mode with an out-of-range index in the middle
        for (int k = 0; k < 3; k++) begin
            b_up_valid = 1'b1;
            b_up_data  = t3[k].data;
            #1;
            chk("ad_up_ready", 32'(b_up_ready), 1);
            tick();
            chk("ad_dn_valid", 32'(b_dn_valid), 32'(t3[k].exp_valid));
            chk("ad_err_sel", 32'(b_err_sel), 32'(t3[k].exp_err_sel));
            if (t3[k].exp_valid != 0) chk("ad_dn_data", b_dn_data, t3[k].data);
        end
        b_up_valid = 1'b0;
        tick();
        chk("ad_err_sel_once", 32'(b_err_sel), 0);
        for (int p = 0; p < 3; p++) begin
            b_dn_done = 5'b00100;
            tick();
            b_dn_done = '0;
            chk("ad_cnt2_drain", 32'(b_err_done), (p == 2) ? 32'd1 : 32'd0);
        end
        chk("ad_busy_idle", 32'(b_busy), 0);

        // Same-cycle reservation and release on child 0, then stray completions
        b_up_valid = 1'b1; b_up_data = 32'h0000_0001;
        tick();
        b_up_data = 32'h0000_0002; b_dn_done = 5'b00001;
        tick();
        chk("sc_no_err", 32'(b_err_done), 0);
        chk("sc_dn_data", b_dn_data, 32'h2);
        b_up_valid = 1'b0; b_dn_done = '0;
        tick();
        chk("sc_busy_cnt1", 32'(b_busy), 1);
        b_dn_done = 5'b00001;
        tick();
        b_dn_done = '0;
        chk("sc_cnt1_release", 32'(b_err_done), 0);
        chk("sc_busy_zero", 32'(b_busy), 0);
        b_dn_done = 5'b00001;
        tick();
        b_dn_done = '0;
        chk("sc_cnt_was_1", 32'(b_err_done), 1);
        tick();
        chk("sc_err_pulse", 32'(b_err_done), 0);
        b_dn_done = 5'b10000;
        tick();
        b_dn_done = '0;
        chk("ed_child4", 32'(b_err_done), 1);
        chk("ed_busy", 32'(b_busy), 0);
        tick();
        chk("ed_pulse_end", 32'(b_err_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
